apb_arb_master: RTL and testbench

- Single APB master shared by NUM_REQ requesters.
- Round-robin arbitration between requesters; sequences each granted transfer through the APB SETUP and ACCESS phases.
- Returns read data or error status to the requester on a tagged response port.
- Sits between test/stimulus agents or CPU-side clients and the APB memory slave; replaces hand-driven per-transfer write/read tasks.

---
 rtl/apb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/apb_arb_master.sv | 134 +++++++++++++
 tb/tb_apb_arb_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB arbitrating master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // One requester's transfer descriptor at the default widths.
  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner and wraps.
// The pointer only moves when the caller confirms a grant via update.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   cand;

  // Pick the first requester after ptr, wrapping at NUM_REQ.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                        = 1'b1;
        grant[cand[IDX_W-1:0]]     = 1'b1;
        grant_idx                  = cand[IDX_W-1:0];
      end
    end
  end

  // Remember the last winner; reset value makes requester 0 the first choice.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst)                ptr <= IDX_W'(NUM_REQ - 1);
    else if (update && any) ptr <= grant_idx;
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by NUM_REQ requesters: round-robin grant in IDLE, then a
// SETUP/ACCESS sequence, then a one-cycle tagged response.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      Rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic                      rsp_valid,
  output logic [IDX_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         PAddr,
  output logic [DATA_W-1:0]         PWData,
  output logic                      PWrite,
  output logic                      PSel,
  output logic                      PEnable,
  input  logic [DATA_W-1:0]         PRData,
  input  logic                      PReady,
  input  logic                      PSlvErr
);

  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  apb_state_e       state;
  req_t             cur;
  req_t             sel_req;
  logic [IDX_W-1:0] cur_id;
  logic [TO_W-1:0]  to_cnt;
  logic             timeout_hit;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (Rst),
    .req       (req_valid),
    .update    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Accept strobe exists only in IDLE and is forced low while reset is held.
  assign accept    = (state == IDLE) && grant_any && !Rst;
  assign req_ready = accept ? grant : '0;

  // Abort when the TIMEOUT-th ACCESS cycle still sees no PReady.
  assign timeout_hit = (TIMEOUT > 0) && (to_cnt == TO_W'(TIMEOUT - 1));

  // Steer the granted requester's payload into the request latch.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_req.write = req_write[i];
        sel_req.addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_req.wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign PAddr  = cur.addr;
  assign PWData = cur.wdata;
  assign PWrite = cur.write;

  // Transfer FSM with registered APB controls and response.
  always_ff @(posedge clk or posedge Rst) begin
    // NOTE: the async reset clears every output flop, so PSel/PEnable fall without waiting for a clock.
    if (Rst) begin
      state     <= IDLE;
      cur       <= '0;
      cur_id    <= '0;
      to_cnt    <= '0;
      PSel      <= 1'b0;
      PEnable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur    <= sel_req;
            cur_id <= grant_idx;
            PSel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PEnable <= 1'b1;
          to_cnt  <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (!PReady) to_cnt <= to_cnt + 1'b1;
          if (PReady || timeout_hit) begin
            PSel      <= 1'b0;
            PEnable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            // PReady takes precedence over a coincident timeout.
            rsp_err   <= PReady ? PSlvErr : 1'b1;
            rsp_rdata <= (PReady && !cur.write) ? PRData : '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master with a small APB slave model.
module tb_apb_arb_master;
  import apb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          Rst;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PAddr;
  logic [DW-1:0] PWData;
  logic          PWrite, PSel, PEnable;
  logic [DW-1:0] PRData;
  logic          PReady, PSlvErr;

  // slave model controls
  logic [DW-1:0] rd_data;
  logic          slv_err;
  logic          stuck;
  int            wait_states;
  int            acc_cnt;
  logic [DW-1:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  apb_arb_master #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PAddr(PAddr), .PWData(PWData), .PWrite(PWrite), .PSel(PSel), .PEnable(PEnable),
    .PRData(PRData), .PReady(PReady), .PSlvErr(PSlvErr)
  );

  always #5 clk = ~clk;

  assign PReady  = !stuck && (acc_cnt >= wait_states);
  assign PRData  = rd_data;
  assign PSlvErr = slv_err;

  always @(posedge clk) begin
    acc_cnt <= (PSel && PEnable && !PReady) ? acc_cnt + 1 : 0;
    if (PSel && PEnable && PReady && PWrite) mem[PAddr[7:0]] <= PWData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input apb_req_t r);
    req_write[i]            = r.write;
    req_addr[i*AW +: AW]    = r.addr;
    req_wdata[i*DW +: DW]   = r.wdata;
  endtask

  // Called in the SETUP cycle; returns in the response cycle.
  task automatic wait_rsp(input string tag, output int acc);
    bit seen;
    acc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      if (PEnable) acc++;
    end
    check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
  endtask

  int acc;
  int gidx [6];
  int gcyc [6];
  int ng;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rd_data = '0; slv_err = 1'b0; stuck = 1'b0; wait_states = 0; acc_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #1;
    check("rst_psel", 32'(PSel), 0);
    check("rst_penable", 32'(PEnable), 0);
    check("rst_paddr", 32'(PAddr), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    req_valid = 4'b1111;
    #1;
    check("rst_ready_gated", 32'(req_ready), 0);
    req_valid = '0;
    step(); step();
    Rst = 1'b0;

    // Write, zero wait states, requester 0
    set_req(0, '{write: 1'b1, addr: 16'h0050, wdata: 32'h0000_0050});
    rd_data   = 32'hAAAA_AAAA;
    req_valid = 4'b0001;
    #1;
    check("wr_ready_T", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    check("wr_setup_psel", 32'(PSel), 1);
    check("wr_setup_penable", 32'(PEnable), 0);
    check("wr_setup_ready", 32'(req_ready), 0);
    step();
    check("wr_access_penable", 32'(PEnable), 1);
    check("wr_paddr", 32'(PAddr), 32'h50);
    check("wr_pwdata", PWData, 32'h50);
    check("wr_pwrite", 32'(PWrite), 1);
    step();
    check("wr_rsp_valid", 32'(rsp_valid), 1);
    check("wr_rsp_id", 32'(rsp_id), 0);
    check("wr_rsp_err", 32'(rsp_err), 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_mem", mem[8'h50], 32'h50);

    // Read with two wait states, requester 2
    set_req(2, '{write: 1'b0, addr: 16'h0010, wdata: 32'h0});
    rd_data     = 32'hDEAD_BEEF;
    wait_states = 2;
    req_valid   = 4'b0100;
    #1;
    check("rd_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    wait_rsp("rd", acc);
    check("rd_access_cycles", 32'(acc), 3);
    check("rd_rsp_id", 32'(rsp_id), 2);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_err", 32'(rsp_err), 0);
    wait_states = 0;

    // Slave error on a read, requester 1
    set_req(1, '{write: 1'b0, addr: 16'h0020, wdata: 32'h0});
    rd_data   = 32'h0000_1234;
    slv_err   = 1'b1;
    req_valid = 4'b0010;
    #1;
    check("se_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    wait_rsp("se", acc);
    check("se_access_cycles", 32'(acc), 1);
    check("se_rsp_id", 32'(rsp_id), 1);
    check("se_rsp_err", 32'(rsp_err), 1);
    check("se_rsp_rdata", rsp_rdata, 32'h1234);
    slv_err = 1'b0;

    // Timeout on requester 3 while requester 0 waits
    set_req(3, '{write: 1'b0, addr: 16'h0030, wdata: 32'h0});
    set_req(0, '{write: 1'b1, addr: 16'h0060, wdata: 32'h0000_0060});
    rd_data   = 32'hFFFF_FFFF;
    stuck     = 1'b1;
    req_valid = 4'b1001;
    #1;
    check("to_ready", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b0001;
    wait_rsp("to", acc);
    check("to_access_cycles", 32'(acc), 16);
    check("to_psel_low", 32'(PSel), 0);
    check("to_rsp_id", 32'(rsp_id), 3);
    check("to_rsp_err", 32'(rsp_err), 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_next_ready", 32'(req_ready), 32'b0001);
    stuck = 1'b0;
    step();
    req_valid = '0;
    wait_rsp("to_next", acc);
    check("to_next_rsp_id", 32'(rsp_id), 0);
    check("to_next_rsp_err", 32'(rsp_err), 0);
    check("to_next_mem", mem[8'h60], 32'h60);

    // Fairness from reset release with all requesters valid
    Rst = 1'b1;
    for (int i = 0; i < NR; i++)
      set_req(i, '{write: 1'b1, addr: 16'(16'h80 + i), wdata: 32'(i)});
    req_valid = 4'b1111;
    step();
    Rst = 1'b0;
    ng  = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      #1;
      if (req_ready != '0) begin
        for (int b = 0; b < NR; b++) if (req_ready[b]) gidx[ng] = b;
        gcyc[ng] = c;
        ng++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    check("fair_grant_count", 32'(ng), 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("fair_order_%0d", k), 32'(gidx[k]), 32'(k % NR));
      if (k > 0) check($sformatf("fair_gap_%0d", k), 32'(gcyc[k] - gcyc[k-1]), 3);
    end
    wait_rsp("fair_last", acc);
    check("fair_last_id", 32'(rsp_id), 1);

    // Reset during ACCESS of requester 2
    set_req(2, '{write: 1'b0, addr: 16'h0070, wdata: 32'h0});
    stuck     = 1'b1;
    req_valid = 4'b0100;
    #1;
    check("mid_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    step();
    check("mid_in_access", 32'(PEnable), 1);
    step();
    Rst       = 1'b1;
    req_valid = 4'b1001;
    #1;
    check("mid_psel_async", 32'(PSel), 0);
    check("mid_penable_async", 32'(PEnable), 0);
    check("mid_ready_gated", 32'(req_ready), 0);
    check("mid_no_rsp", 32'(rsp_valid), 0);
    @(posedge clk);
    #2;
    Rst   = 1'b0;
    stuck = 1'b0;
    #1;
    check("mid_regrant_0", 32'(req_ready), 32'b0001);
    check("mid_no_rsp_idle", 32'(rsp_valid), 0);
    step();
    req_valid = '0;
    check("mid_no_rsp_setup", 32'(rsp_valid), 0);
    wait_rsp("mid_after", acc);
    check("mid_after_id", 32'(rsp_id), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
